// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multi-cycle MIPS control
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// rtl/mips_mc_control_if.sv - control/datapath signal bundle for the multi-cycle MIPS
interface mips_mc_control_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic [OP_W-1:0]  opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             illegal_op;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op, state_o, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op, state_o, instr_count
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state-to-control-line decoder
import mips_ctrl_pkg::*;

module mips_ctrl_outdec (
    input  state_t state,
    input  logic   mem_ready,
    input  logic   op_legal,
    output ctrl_t  ctrl
);

    // Moore decode per state; FETCH latches IR/PC only on the completing cycle
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.illegal_op = ~op_legal;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_SRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - main control FSM and retired-instruction counter
import mips_ctrl_pkg::*;

module mips_mc_control #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mips_mc_control_if.master   bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [OP_W-1:0]  op;
    logic             retire;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl;

    assign op = bus.opcode;

    // Leaving one of the final states of an instruction retires it; an
    // illegal-opcode bounce from DECODE never passes through these states
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_MEMWB  || state_q == S_MEMWR  ||
                     state_q == S_ALUWB  || state_q == S_ADDIWB ||
                     state_q == S_BRANCH || state_q == S_JUMP);

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + 1'b1;
        end
    end

    // Next-state logic; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .op_legal  (is_legal_op(op[5:0])),
        .ctrl      (ctrl_raw)
    );

    // Output stage: reset suppresses every write and request immediately
    always_comb begin
        ctrl = ctrl_raw;
        if (rst) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.illegal_op    = 1'b0;
        end
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state_o       = state_q;
    assign bus.instr_count   = count_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control
module tb_mips_mc_control;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cycles;
    int   pulses;

    mips_mc_control_if #(.OP_W(6), .CNT_W(32)) bus ();

    mips_mc_control #(.OP_W(6), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.opcode = 6'b000000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_ir_write", 32'(bus.ir_write), 32'd0);
        check("rst_pc_write", 32'(bus.pc_write), 32'd0);
        tick();
        tick();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_count", bus.instr_count, 32'd0);
        rst = 1'b0;
        #1;
        check("fetch_mem_read", 32'(bus.mem_read), 32'd1);
        check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        check("fetch_pc_write", 32'(bus.pc_write), 32'd1);
        check("fetch_srcb", 32'(bus.alu_src_b), 32'd1);

        // R-type: 0,1,6,7,0
        bus.opcode = 6'b000000;
        tick();
        check("r_dec_state", 32'(bus.state_o), 32'd1);
        check("r_dec_srcb", 32'(bus.alu_src_b), 32'd3);
        check("r_dec_regw", 32'(bus.reg_write), 32'd0);
        tick();
        check("r_exec_state", 32'(bus.state_o), 32'd6);
        check("r_exec_aluop", 32'(bus.alu_op), 32'd2);
        check("r_exec_srca", 32'(bus.alu_src_a), 32'd1);
        check("r_exec_regdst", 32'(bus.reg_dst), 32'd0);
        tick();
        check("r_wb_state", 32'(bus.state_o), 32'd7);
        check("r_wb_regdst", 32'(bus.reg_dst), 32'd1);
        check("r_wb_regw", 32'(bus.reg_write), 32'd1);
        check("r_wb_m2r", 32'(bus.mem_to_reg), 32'd0);
        tick();
        check("r_done_state", 32'(bus.state_o), 32'd0);
        check("r_done_count", bus.instr_count, 32'd1);
        check("r_done_regw", 32'(bus.reg_write), 32'd0);

        // LW with 3 stall cycles in MEMRD
        bus.opcode = 6'b100011;
        cycles = 0;
        tick(); cycles++;
        check("lw_dec_state", 32'(bus.state_o), 32'd1);
        tick(); cycles++;
        check("lw_adr_state", 32'(bus.state_o), 32'd2);
        check("lw_adr_srcb", 32'(bus.alu_src_b), 32'd2);
        check("lw_adr_srca", 32'(bus.alu_src_a), 32'd1);
        bus.mem_ready = 1'b0;
        tick(); cycles++;
        for (int i = 0; i < 4; i++) begin
            check("lw_rd_state", 32'(bus.state_o), 32'd3);
            check("lw_rd_iord", 32'(bus.iord), 32'd1);
            check("lw_rd_mrd", 32'(bus.mem_read), 32'd1);
            if (i == 3) bus.mem_ready = 1'b1;
            tick(); cycles++;
        end
        check("lw_wb_state", 32'(bus.state_o), 32'd4);
        check("lw_wb_regdst", 32'(bus.reg_dst), 32'd0);
        check("lw_wb_m2r", 32'(bus.mem_to_reg), 32'd1);
        check("lw_wb_regw", 32'(bus.reg_write), 32'd1);
        tick(); cycles++;
        check("lw_done_state", 32'(bus.state_o), 32'd0);
        check("lw_cycles", 32'(cycles), 32'd8);
        check("lw_count", bus.instr_count, 32'd2);

        // BEQ taken then not taken
        for (int k = 0; k < 2; k++) begin
            bus.opcode = 6'b000100;
            bus.zero = (k == 0);
            cycles = 0;
            tick(); cycles++;
            check("beq_dec_state", 32'(bus.state_o), 32'd1);
            tick(); cycles++;
            check("beq_state", 32'(bus.state_o), 32'd8);
            check("beq_pwc", 32'(bus.pc_write_cond), 32'd1);
            check("beq_pcsrc", 32'(bus.pc_src), 32'd1);
            check("beq_aluop", 32'(bus.alu_op), 32'd1);
            check("beq_pcw", 32'(bus.pc_write), 32'd0);
            tick(); cycles++;
            check("beq_done_state", 32'(bus.state_o), 32'd0);
            check("beq_cycles", 32'(cycles), 32'd3);
            check("beq_count", bus.instr_count, 32'(3 + k));
        end

        // FETCH stall, then a J
        bus.opcode = 6'b000010;
        bus.mem_ready = 1'b0;
        #1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.mem_ready = 1'b1;
                #1;
            end
            check("fstall_state", 32'(bus.state_o), 32'd0);
            check("fstall_irw", 32'(bus.ir_write), (i == 2) ? 32'd1 : 32'd0);
            check("fstall_pcw", 32'(bus.pc_write), (i == 2) ? 32'd1 : 32'd0);
            if (bus.ir_write) pulses++;
            tick();
        end
        check("fstall_pulses", 32'(pulses), 32'd1);
        check("j_dec_state", 32'(bus.state_o), 32'd1);
        check("j_dec_irw", 32'(bus.ir_write), 32'd0);
        tick();
        check("j_state", 32'(bus.state_o), 32'd11);
        check("j_pcw", 32'(bus.pc_write), 32'd1);
        check("j_pcsrc", 32'(bus.pc_src), 32'd2);
        tick();
        check("j_done_state", 32'(bus.state_o), 32'd0);
        check("j_count", bus.instr_count, 32'd5);

        // Illegal opcode
        bus.opcode = 6'b111111;
        check("ill_fetch_pulse", 32'(bus.illegal_op), 32'd0);
        tick();
        check("ill_dec_state", 32'(bus.state_o), 32'd1);
        check("ill_pulse", 32'(bus.illegal_op), 32'd1);
        tick();
        check("ill_next_state", 32'(bus.state_o), 32'd0);
        check("ill_pulse_end", 32'(bus.illegal_op), 32'd0);
        check("ill_count", bus.instr_count, 32'd5);

        // ADDI
        bus.opcode = 6'b001000;
        tick();
        check("addi_dec_ill", 32'(bus.illegal_op), 32'd0);
        tick();
        check("addi_ex_state", 32'(bus.state_o), 32'd9);
        check("addi_ex_srcb", 32'(bus.alu_src_b), 32'd2);
        tick();
        check("addi_wb_state", 32'(bus.state_o), 32'd10);
        check("addi_wb_regw", 32'(bus.reg_write), 32'd1);
        check("addi_wb_regdst", 32'(bus.reg_dst), 32'd0);
        tick();
        check("addi_count", bus.instr_count, 32'd6);

        // SW stalled in MEMWR, then reset
        bus.opcode = 6'b101011;
        tick();
        tick();
        check("sw_adr_state", 32'(bus.state_o), 32'd2);
        bus.mem_ready = 1'b0;
        tick();
        check("sw_wr_state", 32'(bus.state_o), 32'd5);
        check("sw_wr_mw", 32'(bus.mem_write), 32'd1);
        check("sw_wr_iord", 32'(bus.iord), 32'd1);
        tick();
        check("sw_stall_state", 32'(bus.state_o), 32'd5);
        check("sw_stall_mw", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("sw_rst_mw", 32'(bus.mem_write), 32'd0);
        tick();
        check("sw_rst_state", 32'(bus.state_o), 32'd0);
        check("sw_rst_count", bus.instr_count, 32'd0);
        check("sw_rst_mrd", 32'(bus.mem_read), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_mrd", 32'(bus.mem_read), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
